// File: rtl/io_bus_pkg.sv
// Shared bus constants, responder FSM states and a saturating-count helper
// for the IO board responder.
package io_bus_pkg;

  localparam int IO_ADDR_W = 4;
  localparam int IO_DATA_W = 8;
  localparam int IO_EN_RD  = 0;
  localparam int IO_EN_WR  = 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RD_DRIVE     = 2'd1,
    WR_SETTLE    = 2'd2,
    WAIT_RELEASE = 2'd3
  } io_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/io_sync.sv
// Two-flop synchronizer for an asynchronous bus, idling at all ones.
module io_sync #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: flops use non-blocking assignments so both stages sample
  // their inputs from before the edge and the chain stays two deep.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/io_board_responder.sv
// IO board bus responder: synchronizes an asynchronous strobe bus, answers
// reads from in_pins, loads out_pins on writes, with watchdog and error count.
module io_board_responder
  import io_bus_pkg::*;
#(
  parameter logic [IO_ADDR_W-1:0] BOARD_ADDR    = 4'd0,
  parameter int                   SETTLE_CYCLES = 2,
  parameter logic [23:0]          WDT_CYCLES    = 24'd100000,
  parameter logic [IO_DATA_W-1:0] OUT_SAFE      = 8'h00
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [IO_ADDR_W-1:0] io_address,
  input  logic [1:0]           io_enable_n,
  inout  wire  [IO_DATA_W-1:0] io_data,
  input  logic [IO_DATA_W-1:0] in_pins,
  output logic [IO_DATA_W-1:0] out_pins,
  output logic                 out_update,
  output logic                 wdt_expired,
  output logic [7:0]           err_count
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  logic [IO_ADDR_W-1:0] addr_s;
  logic [1:0]           en_s;
  logic [IO_DATA_W-1:0] data_s;

  io_sync #(.WIDTH(IO_ADDR_W)) u_sync_addr (.Clk(Clk), .Rst(Rst), .async_in(io_address),  .sync_out(addr_s));
  io_sync #(.WIDTH(2))         u_sync_en   (.Clk(Clk), .Rst(Rst), .async_in(io_enable_n), .sync_out(en_s));
  io_sync #(.WIDTH(IO_DATA_W)) u_sync_data (.Clk(Clk), .Rst(Rst), .async_in(io_data),     .sync_out(data_s));

  io_state_e            state_q, state_d;
  logic [1:0]           en_prev_q, en_prev_d;
  logic [7:0]           settle_q, settle_d;
  logic [IO_DATA_W-1:0] rd_latch_q, rd_latch_d;
  logic [IO_DATA_W-1:0] out_pins_q, out_pins_d;
  logic                 out_update_q, out_update_d;
  logic [23:0]          wdt_q, wdt_d;
  logic                 wdt_expired_q, wdt_expired_d;
  logic [7:0]           err_q, err_d;

  logic rd_fall, wr_fall, addr_hit, both_low_new, capture, err_event;

  assign rd_fall      = en_prev_q[IO_EN_RD] & ~en_s[IO_EN_RD];
  assign wr_fall      = en_prev_q[IO_EN_WR] & ~en_s[IO_EN_WR];
  assign addr_hit     = (addr_s == BOARD_ADDR);
  assign both_low_new = (en_s == 2'b00) && (en_prev_q != 2'b00);

  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    en_prev_d     = en_s;
    settle_d      = settle_q;
    rd_latch_d    = rd_latch_q;
    out_pins_d    = out_pins_q;
    out_update_d  = 1'b0;
    wdt_d         = (wdt_q != 24'd0) ? wdt_q - 24'd1 : wdt_q;
    wdt_expired_d = wdt_expired_q;
    err_d         = err_q;
    capture       = 1'b0;
    err_event     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_fall && en_s[IO_EN_WR]) begin
          if (addr_hit) begin
            rd_latch_d = in_pins;
            state_d    = RD_DRIVE;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end else if (wr_fall && en_s[IO_EN_RD]) begin
          if (addr_hit) begin
            settle_d = SETTLE_LOAD;
            state_d  = WR_SETTLE;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end
      end
      RD_DRIVE: if (en_s[IO_EN_RD]) state_d = IDLE;
      WR_SETTLE: begin
        if (en_s[IO_EN_WR] || !addr_hit) begin
          err_event = 1'b1;
          state_d   = WAIT_RELEASE;
        end else if (settle_q == 8'd0) begin
          capture = 1'b1;
          state_d = WAIT_RELEASE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      WAIT_RELEASE: if (en_s == 2'b11) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus contention overrides whatever the state machine decided.
    if (both_low_new) begin
      err_event = 1'b1;
      capture   = 1'b0;
      state_d   = WAIT_RELEASE;
    end

    if (capture) begin
      out_pins_d    = data_s;
      out_update_d  = 1'b1;
      wdt_d         = WDT_CYCLES;
      wdt_expired_d = 1'b0;
    end else if (wdt_q == 24'd1) begin
      out_pins_d    = OUT_SAFE;
      wdt_expired_d = 1'b1;
    end

    if (err_event) err_d = sat_inc8(err_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      en_prev_q     <= 2'b11;
      settle_q      <= 8'd0;
      out_pins_q    <= OUT_SAFE;
      out_update_q  <= 1'b0;
      wdt_q         <= WDT_CYCLES;
      wdt_expired_q <= 1'b0;
      err_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      en_prev_q     <= en_prev_d;
      settle_q      <= settle_d;
      out_pins_q    <= out_pins_d;
      out_update_q  <= out_update_d;
      wdt_q         <= wdt_d;
      wdt_expired_q <= wdt_expired_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the read latch is pure data, always written before it is driven,
  // so it carries no reset.
  always_ff @(posedge Clk) rd_latch_q <= rd_latch_d;

  // Release follows the raw strobe so the bus frees as soon as it rises.
  assign io_data = (state_q == RD_DRIVE && !io_enable_n[IO_EN_RD]) ? rd_latch_q : 'z;

  assign out_pins    = out_pins_q;
  assign out_update  = out_update_q;
  assign wdt_expired = wdt_expired_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_io_board_responder.sv
// Directed plus randomized bench for io_board_responder against a
// transaction-level model of outputs, watchdog and error count.
module tb_io_board_responder;

  localparam logic [3:0] BADDR = 4'd3;
  localparam int         WDT   = 50;
  localparam logic [7:0] SAFE  = 8'h00;
  localparam logic [7:0] RELEASED = 8'hFF;   // pulled-up idle bus value

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] io_address = 4'd0;
  logic [1:0] io_enable_n = 2'b11;
  logic [7:0] in_pins = 8'h00;
  logic [7:0] out_pins;
  logic       out_update;
  logic       wdt_expired;
  logic [7:0] err_count;
  tri1  [7:0] io_data;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;

  assign io_data = drv_en ? drv_val : 'z;

  io_board_responder #(
    .BOARD_ADDR(BADDR), .SETTLE_CYCLES(2), .WDT_CYCLES(24'(WDT)), .OUT_SAFE(SAFE)
  ) dut (
    .Clk(Clk), .Rst(Rst), .io_address(io_address), .io_enable_n(io_enable_n),
    .io_data(io_data), .in_pins(in_pins), .out_pins(out_pins),
    .out_update(out_update), .wdt_expired(wdt_expired), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  int upd_cnt = 0;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (out_update === 1'b1) upd_cnt++;

  int total = 0;
  int bad = 0;

  // Transaction-level model state.
  int         last_cap;
  logic [7:0] last_data;
  int         err_exp;
  int         upd_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_out();
    return (cyc >= last_cap + WDT) ? SAFE : last_data;
  endfunction

  function automatic logic exp_wdt();
    return cyc >= last_cap + WDT;
  endfunction

  task automatic model_err();
    if (err_exp < 255) err_exp++;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; io_enable_n = 2'b11; drv_en = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    last_cap = cyc; last_data = SAFE; err_exp = 0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input int len, output int fall_cyc);
    @(negedge Clk);
    io_address = a; drv_val = d; drv_en = 1'b1; io_enable_n = 2'b01;
    fall_cyc = cyc;
    repeat (len) @(negedge Clk);
    io_enable_n = 2'b11; drv_en = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic bus_read(input logic [3:0] a, input int len, input logic [7:0] pins);
    logic hit;
    hit = (a == BADDR);
    @(negedge Clk);
    in_pins = pins; io_address = a; io_enable_n = 2'b10;
    repeat (2) @(posedge Clk);
    #1 check("rd_before_drive", io_data, RELEASED);
    @(posedge Clk);
    #1 check("rd_drive", io_data, hit ? pins : RELEASED);
    @(negedge Clk);
    in_pins = ~pins;
    @(posedge Clk);
    #1 check("rd_snapshot", io_data, hit ? pins : RELEASED);
    repeat (len - 3) @(negedge Clk);
    io_enable_n = 2'b11;
    #1 check("rd_release", io_data, RELEASED);
    repeat (6) @(negedge Clk);
  endtask

  task automatic both_low();
    @(negedge Clk);
    io_enable_n = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk);
      #1 check("both_low_hiz", io_data, RELEASED);
    end
    @(negedge Clk);
    io_enable_n = 2'b11;
    repeat (6) @(negedge Clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out"}, out_pins, exp_out());
    check({tag, "_wdt"}, wdt_expired, exp_wdt());
    check({tag, "_err"}, err_count, 8'(err_exp));
    check({tag, "_upd"}, upd_cnt, upd_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int f;
    int c;
    logic [3:0] a;
    logic [7:0] d;
    int kind;
    upd_exp = 0;

    // Reset state.
    do_reset();
    check("rst_out", out_pins, SAFE);
    check("rst_upd", out_update, 1'b0);
    check("rst_wdt", wdt_expired, 1'b0);
    check("rst_err", err_count, 8'd0);
    check("rst_bus", io_data, RELEASED);

    // Write latency: out_pins changes exactly six cycles after the strobe falls.
    @(negedge Clk);
    io_address = BADDR; drv_val = 8'hA5; drv_en = 1'b1; io_enable_n = 2'b01;
    c = cyc;
    repeat (5) @(posedge Clk);
    #1 check("wr_lat_early", out_pins, SAFE);
    @(posedge Clk);
    #1 check("wr_lat_exact", out_pins, 8'hA5);
    check("wr_upd_high", out_update, 1'b1);
    @(posedge Clk);
    #1 check("wr_upd_low", out_update, 1'b0);
    repeat (4) @(negedge Clk);
    io_enable_n = 2'b11; drv_en = 1'b0;
    repeat (6) @(negedge Clk);
    last_cap = c + 6; last_data = 8'hA5; upd_exp = 1;
    check_model("wr_a5");

    // Read of in_pins, then a write to a foreign address.
    bus_read(BADDR, 6, 8'h3C);
    bus_write(4'd5, 8'h11, 10, f);
    check_model("wr_foreign");

    // Both enables low together.
    both_low();
    model_err();
    check_model("both_low");

    // Short write strobe aborts, then saturation.
    do_reset();
    bus_write(BADDR, 8'h77, 3, f);
    model_err();
    check_model("short_wr");
    for (int i = 0; i < 300; i++) begin
      bus_write(BADDR, 8'h5A, 3, f);
      model_err();
    end
    check("err_saturate", err_count, 8'hFF);
    check("err_sat_out", out_pins, SAFE);

    // Watchdog expiry and recovery.
    do_reset();
    bus_write(BADDR, 8'hFF, 10, f);
    last_cap = f + 6; last_data = 8'hFF; upd_exp++;
    while (cyc < last_cap + WDT - 1) begin
      @(posedge Clk);
      #1;
    end
    check("wdt_before_out", out_pins, 8'hFF);
    check("wdt_before_flag", wdt_expired, 1'b0);
    @(posedge Clk);
    #1 check("wdt_at_out", out_pins, SAFE);
    check("wdt_at_flag", wdt_expired, 1'b1);
    check("wdt_no_upd", upd_cnt, upd_exp);
    bus_write(BADDR, 8'h0F, 10, f);
    last_cap = f + 6; last_data = 8'h0F; upd_exp++;
    check_model("wdt_recover");

    // Reset pulsed while a write is settling.
    @(negedge Clk);
    io_address = BADDR; drv_val = 8'hC3; drv_en = 1'b1; io_enable_n = 2'b01;
    repeat (4) @(posedge Clk);
    do_reset();
    repeat (8) @(negedge Clk);
    check_model("rst_mid_wr");
    bus_read(BADDR, 6, 8'h96);

    // Randomized transactions against the model.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a = ($urandom_range(0, 3) == 0) ? 4'(4'd3 + 4'($urandom_range(1, 15))) : BADDR;
      d = 8'($urandom);
      case (kind)
        0, 1: begin
          bus_write(a, d, 10, f);
          if (a == BADDR) begin
            last_cap = f + 6; last_data = d; upd_exp++;
          end
        end
        2: begin
          bus_write(a, d, 3, f);
          if (a == BADDR) model_err();
        end
        3: bus_read(a, 6, d);
        default: begin
          both_low();
          model_err();
        end
      endcase
      repeat ($urandom_range(0, 30)) @(negedge Clk);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
